// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: command codes, FSM state
// encoding and helpers used by the top level and the iterative datapath.
package seq_alu_pkg;

  localparam int unsigned CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_ADD   = 4'd0;
  localparam logic [CMD_W-1:0] CMD_SUB   = 4'd1;
  localparam logic [CMD_W-1:0] CMD_XOR   = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SLT   = 4'd3;
  localparam logic [CMD_W-1:0] CMD_AND   = 4'd4;
  localparam logic [CMD_W-1:0] CMD_NAND  = 4'd5;
  localparam logic [CMD_W-1:0] CMD_NOR   = 4'd6;
  localparam logic [CMD_W-1:0] CMD_OR    = 4'd7;
  localparam logic [CMD_W-1:0] CMD_SLTU  = 4'd8;
  localparam logic [CMD_W-1:0] CMD_MULT  = 4'd9;
  localparam logic [CMD_W-1:0] CMD_MULTU = 4'd10;
  localparam logic [CMD_W-1:0] CMD_DIV   = 4'd11;
  localparam logic [CMD_W-1:0] CMD_DIVU  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic is_muldiv(input logic [CMD_W-1:0] cmd);
    return (cmd >= CMD_MULT) && (cmd <= CMD_DIVU);
  endfunction

  function automatic logic is_div(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_DIV) || (cmd == CMD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per step_i cycle.
// Ports:
//   load_i        capture operands/command (accepting edge of a mul/div)
//   step_i        perform one iteration
//   cmd_i,a_i,b_i command and operands sampled on load_i
//   last_c        the current step is the final (WIDTH-th) iteration
//   lo_c,hi_c     sign-corrected result / product-high or remainder
//   ovf_c         divide-by-zero or signed-division overflow
module muldiv_iter
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_c,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c,
  output logic             ovf_c
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned W1    = WIDTH + 1;
  localparam int unsigned W2    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // acc holds the product high half / partial remainder,
  // mq holds the multiplier being shifted out / the quotient being built.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic             dovf_q, dovf_d;

  logic             sgn_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [W1-1:0]    add_c;
  logic [W1-1:0]    sub_c;
  logic [W2-1:0]    prod_c;

  // Operand conditioning: signed ops work on magnitudes.
  always_comb begin
    sgn_c   = (cmd_i == CMD_MULT) || (cmd_i == CMD_DIV);
    a_neg_c = sgn_c & a_i[WIDTH-1];
    b_neg_c = sgn_c & b_i[WIDTH-1];
    a_mag_c = a_neg_c ? -a_i : a_i;
    b_mag_c = b_neg_c ? -b_i : b_i;
  end

  // Per-iteration arithmetic for both operations.
  always_comb begin
    add_c = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : W1'(0));
    sub_c = {acc_q, mq_q[WIDTH-1]} - {1'b0, opb_q};
  end

  // Next-state of the datapath registers.
  always_comb begin
    acc_d    = acc_q;
    mq_d     = mq_q;
    opb_d    = opb_q;
    a_raw_d  = a_raw_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    dovf_d   = dovf_q;
    if (load_i) begin
      acc_d    = '0;
      mq_d     = a_mag_c;
      opb_d    = b_mag_c;
      a_raw_d  = a_i;
      cnt_d    = '0;
      div_d    = is_div(cmd_i);
      neg_lo_d = a_neg_c ^ b_neg_c;
      neg_hi_d = a_neg_c;
      div0_d   = is_div(cmd_i) && (b_i == '0);
      dovf_d   = (cmd_i == CMD_DIV) && (a_i == MOST_NEG) && (b_i == '1);
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        // Restoring step: keep the subtraction only when it did not borrow.
        if (!sub_c[WIDTH]) begin
          acc_d = sub_c[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = add_c[W1-1:1];
        mq_d  = {add_c[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      a_raw_q  <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      dovf_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      a_raw_q  <= a_raw_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      dovf_q   <= dovf_d;
    end
  end

  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

  // Sign correction and special cases, consumed by the top in FIX.
  always_comb begin
    prod_c = {acc_q, mq_q};
    lo_c   = mq_q;
    hi_c   = acc_q;
    ovf_c  = 1'b0;
    if (div_q) begin
      if (div0_q) begin
        lo_c  = '1;
        hi_c  = a_raw_q;
        ovf_c = 1'b1;
      end else if (dovf_q) begin
        lo_c  = a_raw_q;
        hi_c  = '0;
        ovf_c = 1'b1;
      end else begin
        if (neg_lo_q) lo_c = -mq_q;
        if (neg_hi_q) hi_c = -acc_q;
      end
    end else if (neg_lo_q) begin
      {hi_c, lo_c} = -prod_c;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative
// multiply/divide, sequenced by an IDLE/RUN/FIX/DONE FSM.
// Ports:
//   start,command,operand_a,operand_b  request, sampled only while idle
//   busy       operation in progress (start ignored)
//   done       one-cycle pulse when result/hi/flags are valid
//   result,hi  primary result and product-high / remainder
//   zero,overflow,carryout  status flags, held until the next completion
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             carryout
);

  localparam int unsigned W1 = WIDTH + 1;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load_c;
  logic             step_c;
  logic [W1-1:0]    add_c;
  logic [W1-1:0]    sub_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c;
  logic             alu_cout_c;
  logic             md_last_c;
  logic [WIDTH-1:0] md_lo_c;
  logic [WIDTH-1:0] md_hi_c;
  logic             md_ovf_c;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_c),
    .step_i (step_c),
    .cmd_i  (command),
    .a_i    (operand_a),
    .b_i    (operand_b),
    .last_c (md_last_c),
    .lo_c   (md_lo_c),
    .hi_c   (md_hi_c),
    .ovf_c  (md_ovf_c)
  );

  // Single-cycle ops, evaluated directly on the inputs at the accepting edge.
  always_comb begin
    add_c      = {1'b0, operand_a} + {1'b0, operand_b};
    sub_c      = {1'b0, operand_a} + {1'b0, ~operand_b} + W1'(1);
    alu_res_c  = add_c[WIDTH-1:0];
    alu_cout_c = 1'b0;
    alu_ovf_c  = 1'b0;
    case (command)
      CMD_SUB: begin
        alu_res_c  = sub_c[WIDTH-1:0];
        alu_cout_c = sub_c[WIDTH];
        alu_ovf_c  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                     (sub_c[WIDTH-1] != operand_a[WIDTH-1]);
      end
      CMD_XOR:  alu_res_c = operand_a ^ operand_b;
      CMD_SLT:  alu_res_c = WIDTH'($signed(operand_a) < $signed(operand_b));
      CMD_AND:  alu_res_c = operand_a & operand_b;
      CMD_NAND: alu_res_c = ~(operand_a & operand_b);
      CMD_NOR:  alu_res_c = ~(operand_a | operand_b);
      CMD_OR:   alu_res_c = operand_a | operand_b;
      CMD_SLTU: alu_res_c = WIDTH'(operand_a < operand_b);
      default: begin
        // ADD, and reserved codes which execute as ADD
        alu_cout_c = add_c[WIDTH];
        alu_ovf_c  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                     (add_c[WIDTH-1] != operand_a[WIDTH-1]);
      end
    endcase
  end

  // FSM next-state and registered-output updates.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    load_c   = 1'b0;
    step_c   = (state_q == RUN);
    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d = command;
          if (is_muldiv(command)) begin
            load_c  = 1'b1;
            state_d = RUN;
          end else begin
            state_d  = DONE;
            result_d = alu_res_c;
            hi_d     = '0;
            zero_d   = (alu_res_c == '0);
            ovf_d    = alu_ovf_c;
            cout_d   = alu_cout_c;
          end
        end
      end
      RUN: begin
        if (md_last_c) state_d = FIX;
      end
      FIX: begin
        state_d  = DONE;
        result_d = md_lo_c;
        hi_d     = md_hi_c;
        ovf_d    = md_ovf_c;
        cout_d   = 1'b0;
        // Products are zero only if both halves are; division tests the quotient.
        zero_d   = (md_lo_c == '0) && (is_div(cmd_q) || (md_hi_c == '0));
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign hi       = hi_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign carryout = cout_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): directed vectors push expected
// responses; a monitor pops and compares on every done pulse.
module tb_seq_alu;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       command;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             carryout;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .command   (command),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .overflow  (overflow),
    .carryout  (carryout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        c;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cycle_cnt = 0;
  int   vec_id    = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s busy", tag),     64'(busy),     64'(0));
    check($sformatf("%s done", tag),     64'(done),     64'(0));
    check($sformatf("%s result", tag),   64'(result),   64'(0));
    check($sformatf("%s hi", tag),       64'(hi),       64'(0));
    check($sformatf("%s zero", tag),     64'(zero),     64'(0));
    check($sformatf("%s overflow", tag), 64'(overflow), 64'(0));
    check($sformatf("%s carryout", tag), 64'(carryout), 64'(0));
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected done", 64'(done), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check($sformatf("vec%0d result", e.tag),   64'(result),   64'(e.res));
        check($sformatf("vec%0d hi", e.tag),       64'(hi),       64'(e.hi));
        check($sformatf("vec%0d zero", e.tag),     64'(zero),     64'(e.z));
        check($sformatf("vec%0d overflow", e.tag), 64'(overflow), 64'(e.o));
        check($sformatf("vec%0d carryout", e.tag), 64'(carryout), 64'(e.c));
        check($sformatf("vec%0d latency", e.tag),
              64'(cycle_cnt - e.start_cyc), 64'(e.lat));
      end
    end
  end

  // Called at a negedge with the DUT idle; scrambles operands after acceptance.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [31:0] h,
                       input logic z, input logic o, input logic c, input int lat);
    exp_t e;
    start     = 1'b1;
    command   = cmd;
    operand_a = a;
    operand_b = b;
    e.tag       = vec_id;
    e.res       = res;
    e.hi        = h;
    e.z         = z;
    e.o         = o;
    e.c         = c;
    e.lat       = lat;
    e.start_cyc = cycle_cnt;
    vec_id++;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    command   = 4'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done timeout", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    command   = 4'd0;
    operand_a = '0;
    operand_b = '0;
    #2;
    check_reset("por");
    repeat (3) @(negedge clk);

    // Start presented together with reset release: accepted on the first edge.
    rst_n = 1'b1;
    issue(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1);
    wait_done();
    issue(4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1);
    wait_done();
    issue(4'd8,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    wait_done();
    issue(4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    wait_done();
    issue(4'd2,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    wait_done();
    issue(4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    wait_done();
    issue(4'd6,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    wait_done();
    issue(4'd15, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 32'h0, 1'b0, 1'b0, 1'b0, 1);
    wait_done();
    issue(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1);
    wait_done();

    // Multiply / divide, done WIDTH+2 cycles after start.
    issue(4'd9,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 34);
    wait_done();
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 34);
    wait_done();
    issue(4'd9,  32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 34);
    wait_done();
    issue(4'd11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 34);
    wait_done();
    issue(4'd12, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 34);
    wait_done();
    issue(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 34);
    wait_done();
    issue(4'd12, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 1'b0, 34);
    wait_done();

    // Starts while busy and coincident with done must be ignored.
    issue(4'd10, 32'd1000, 32'd3, 32'd3000, 32'd0, 1'b0, 1'b0, 1'b0, 34);
    repeat (5) @(negedge clk);
    start = 1'b1; command = 4'd0; operand_a = 32'd1; operand_b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ignore: done seen", 64'(done), 64'(1));
    start = 1'b1; command = 4'd0; operand_a = 32'd1; operand_b = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("ignore: idle afterwards", 64'(busy), 64'(0));

    // Reset during iteration 10 of a divide.
    start = 1'b1; command = 4'd11; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid-div busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset("mid-div reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post-reset idle", 64'(busy), 64'(0));
    issue(4'd0, 32'd10, 32'd20, 32'd30, 32'd0, 1'b0, 1'b0, 1'b0, 1);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 8..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: requests an operation; sampled only while busy=0.
REQ-005 SHALL have port command, input, 4 bits: operation code per REQ-012.
REQ-006 SHALL have ports operand_a and operand_b, input, WIDTH bits each: two's-complement operands, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: operation in progress; start is ignored while it is high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 SHALL have port result, output, WIDTH bits: primary result (LO, quotient, or logic/arith result).
REQ-010 SHALL have port hi, output, WIDTH bits: product upper half or remainder; 0 for single-cycle ops.
REQ-011 SHALL have ports zero, overflow and carryout, output, 1 bit each: status flags.

Function
REQ-012 SHALL decode command as:
- 0 ADD, 1 SUB, 2 XOR, 3 SLT (signed), 4 AND, 5 NAND, 6 NOR, 7 OR, 8 SLTU
- 9 MULT, 10 MULTU, 11 DIV, 12 DIVU
- 13-15 reserved, executing as ADD.
REQ-013 SHALL run an FSM with states IDLE, RUN, FIX and DONE.
- IDLE->DONE on start with command 0-8.
- IDLE->RUN on start with command 9-12.
- RUN->FIX after exactly WIDTH iterations.
- FIX->DONE.
- DONE->IDLE unconditionally.
REQ-014 SHALL capture operands and command at the edge accepting start; later operand changes SHALL NOT affect the running operation.
REQ-015 SHALL assert done during DONE only, i.e. 1 cycle after the accepting edge for commands 0-8 and WIDTH+2 cycles after it for commands 9-12.
REQ-016 SHALL hold busy high in RUN, FIX and DONE; a start coincident with done SHALL be ignored.
REQ-017 SHALL hold result, hi and the flags stable from done until the next accepted start completes.
REQ-018 SHALL compute ADD/SUB with WIDTH+1-bit arithmetic.
- carryout SHALL be bit WIDTH of the sum; SUB SHALL use A + ~B + 1.
- overflow SHALL be signed overflow.
- Both flags SHALL be 0 for all other commands 0-8.
REQ-019 SHALL implement MULT/MULTU as radix-2 shift-add over WIDTH iterations, giving {hi,result} = the full 2*WIDTH-bit product.
- Signed operands SHALL be handled by magnitude multiplication plus negation in FIX.
REQ-020 SHALL implement DIV/DIVU as restoring division over WIDTH iterations.
- Signed DIV SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign (corrected in FIX).
REQ-021 SHALL return result = all ones, hi = operand_a and overflow=1 for divide by zero.
REQ-022 SHALL return result = operand_a, hi = 0 and overflow=1 for signed DIV of the most negative value by -1.
REQ-023 SHALL set zero=1 iff result==0 (and hi==0 for MULT/MULTU), for every command.
REQ-024 SHALL set carryout=0 for commands 9-12, and overflow=0 for them except per REQ-021/022.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE and busy=0, done=0, result=0, hi=0, zero=0, overflow=0, carryout=0, independent of clk.
REQ-026 SHALL abort any operation in progress when reset is asserted mid-operation; no done SHALL follow the deassertion.
REQ-027 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place the command codes, the FSM state encoding and the width of the iteration counter ($clog2(WIDTH+1)) in shared package seq_alu_pkg.
REQ-029 SHALL isolate the iterative multiply/divide datapath (accumulator, shift register, counter) in sub-module muldiv_iter, with the FSM and single-cycle ops in seq_alu.

Verification (WIDTH=32)
REQ-030 SHALL cover ADD: 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, carryout=0; done exactly 1 cycle after start.
REQ-031 SHALL cover SUB: 5-5 -> result 0, zero=1, carryout=1; then SLTU 1,0xFFFFFFFF -> result 1.
REQ-032 SHALL cover MULT: -3 * 7 -> hi 0xFFFFFFFF, result 0xFFFFFFEB; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, result 1; done 34 cycles after start.
REQ-033 SHALL cover DIV: -7/2 -> result 0xFFFFFFFD, hi 0xFFFFFFFF; DIVU 7/0 -> result 0xFFFFFFFF, hi 7, overflow=1.
REQ-034 SHALL cover a start pulsed while busy with different operands -> ignored, and the original result is delivered unchanged.
REQ-035 SHALL cover rst_n low at iteration 10 of a DIV -> all outputs 0 immediately, no done after release, and a new ADD completes normally.
